alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU, including the RED, PADDSB and CLA-based adders.
- Captures decoded operands and register IDs each cycle.
- Detects load-use hazards and inserts bubbles.
- Resolves EX/MEM and MEM/WB forwarding, so the ALU always sees correct 16-bit A/B operands.
- Sole source of ALU operands in the 16-bit datapath.

Parameters:
- DW, 16, datapath width.
- RW, 4, register-ID width; register 0 reads as zero.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  4  decoded opcode (1000=LW, 0011=RED, ...)
- id_rs, id_rt, id_rd  in  RW each  source and destination register IDs
- id_use_rs, id_use_rt  in  1 each  instruction reads rs/rt
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_use_imm  in  1  B operand is the immediate
- id_wr_en  in  1  instruction writes rd
- stall_in  in  1  downstream stall, hold the stage
- flush  in  1  squash the instruction being captured and the held one
- exm_wr_en, exm_rd, exm_data  in  1/RW/DW  EX/MEM writeback info
- mwb_wr_en, mwb_rd, mwb_data  in  1/RW/DW  MEM/WB writeback info
- hazard_stall  out  1  combinational; upstream holds PC and IF/ID
- ex_valid  out  1  registered valid
- ex_opcode  out  4  registered opcode
- ex_rd  out  RW  registered destination
- ex_wr_en  out  1  registered; gated by ex_valid
- ex_op_a, ex_op_b  out  DW  forwarded ALU operands (combinational from registers + fwd inputs)

Behaviour:
- Reset (rst_n low, async): ex_valid=0, ex_wr_en=0, ex_opcode=0, ex_rd=0. Internal captured data, IDs and use flags =0, so ex_op_a=ex_op_b=0 with no forwarding inputs active.
- Hazard: hazard_stall=1 when all of the following hold:
  - ex_valid=1, ex_opcode=1000, ex_rd!=0;
  - id_valid=1 and !flush;
  - (id_use_rs && id_rs==ex_rd) or (id_use_rt && id_rt==ex_rd).
- Per-edge priority, highest first:
  1. flush: ex_valid<=0, ex_wr_en<=0.
  2. stall_in: all registers hold. hazard_stall is still reported but has no effect.
  3. hazard_stall: insert bubble, ex_valid<=0, ex_wr_en<=0.
  4. Otherwise: capture all id_* fields. ex_valid<=id_valid, ex_wr_en<=id_wr_en&id_valid.
- Capture-time bypass: when mwb_wr_en and mwb_rd==id_rs (rs!=0), mwb_data is captured in place of id_rs_data. Same rule for rt. This covers the register-file write/read in the same cycle.
- Operand A:
  - captured rs==0 or !use_rs -> 0;
  - else exm_wr_en && exm_rd==rs -> exm_data;
  - else mwb_wr_en && mwb_rd==rs -> mwb_data;
  - else captured value.
  - EX/MEM always beats MEM/WB.
- Operand B: same forwarding on rt. When use_imm=1, ex_op_b = captured imm and no forwarding applies.
- Forwarding outputs are valid only while ex_valid=1. Values during a bubble are don't-care but must not be X.
- Single-cycle latency, ID to ex_*. Bubble costs exactly one cycle per load-use.
- Mid-operation reset clears valid immediately, with no clock edge needed.

Optional Feature:
- Macro OPSTAGE_PERF_CNT_EN.
- When defined, adds two outputs, perf_bubbles [15:0] and perf_fwds [15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - perf_bubbles increments on each hazard-inserted bubble (not flushes, not stall_in cycles).
  - perf_fwds increments once per cycle in which ex_valid=1, stall_in=0, and either operand is taken from exm/mwb.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: ex_valid=1 with ADD captured, assert rst_n=0 between edges -> ex_valid=0 and ex_op_a=0 immediately, before the next clk edge.
- Back-to-back forward: ADD r3 (exm_data=16'h1234) then RED using rs=r3, rt=r3 -> ex_op_a=ex_op_b=16'h1234. If mwb_rd=r3 with data 16'h5555 at the same time, EX/MEM still wins.
- Load-use: LW r5 in EX, ID=ADD rs=r5 -> hazard_stall=1 for one cycle, bubble (ex_valid=0), then ADD captured and forwarded via mwb once the load reaches MEM/WB.
- Register 0: id_rs=0, id_rs_data=16'hFFFF, exm_rd=0 with exm_wr_en=1 -> ex_op_a=0. LW r0 followed by a use of r0 -> no hazard_stall.
- Flush vs stall: stall_in=1 and flush=1 on the same edge -> ex_valid=0. stall_in=1 alone for 3 cycles -> all ex_* hold their values.
- Immediate: id_use_imm=1, id_imm=16'h00F0, exm_rd==id_rt -> ex_op_b=16'h00F0. With OPSTAGE_PERF_CNT_EN, two load-use events -> perf_bubbles=2.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU (RED, PADDSB and CLA adders).
// It captures the decoded operands and register IDs, inserts a bubble on
// load-use hazards, and resolves EX/MEM and MEM/WB forwarding, so ex_op_a and
// ex_op_b are always the up-to-date 16-bit operands.
// Optional feature: define OPSTAGE_PERF_CNT_EN to add the saturating
// perf_bubbles and perf_fwds counters.
module alu_operand_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic          id_wr_en,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [3:0]    ex_opcode,
  output logic [RW-1:0] ex_rd,
  output logic          ex_wr_en,
  output logic [DW-1:0] ex_op_a,
  output logic [DW-1:0] ex_op_b
`ifdef OPSTAGE_PERF_CNT_EN
  ,
  output logic [15:0]   perf_bubbles,
  output logic [15:0]   perf_fwds
`endif
);

  localparam logic [3:0] OP_LW = 4'b1000;

  logic          r_valid, r_wr_en, r_use_rs, r_use_rt, r_use_imm;
  logic [3:0]    r_opcode;
  logic [RW-1:0] r_rd, r_rs, r_rt;
  logic [DW-1:0] r_rs_data, r_rt_data, r_imm;
  logic [DW-1:0] w_rs_cap, w_rt_cap;
  logic          w_fwd_a, w_fwd_b;

  assign ex_valid  = r_valid;
  assign ex_wr_en  = r_wr_en;
  assign ex_opcode = r_opcode;
  assign ex_rd     = r_rd;

  // Load in EX whose result the instruction in ID needs: hold ID for a cycle.
  always_comb begin
    hazard_stall = 1'b0;
    if (r_valid && r_opcode == OP_LW && r_rd != '0 && id_valid && !flush)
      hazard_stall = (id_use_rs && id_rs == r_rd) || (id_use_rt && id_rt == r_rd);
  end

  // The register file is written and read in the same cycle; take the WB
  // value directly so the captured operand is never stale.
  always_comb begin
    w_rs_cap = id_rs_data;
    w_rt_cap = id_rt_data;
    if (mwb_wr_en && id_rs != '0 && mwb_rd == id_rs) w_rs_cap = mwb_data;
    if (mwb_wr_en && id_rt != '0 && mwb_rd == id_rt) w_rt_cap = mwb_data;
  end

  // Pipeline register: flush > stall_in > hazard bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_use_rs  <= 1'b0;
      r_use_rt  <= 1'b0;
      r_use_imm <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_wr_en <= 1'b0;
    end else if (stall_in) begin
      r_valid <= r_valid;
    end else if (hazard_stall) begin
      r_valid <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_valid   <= id_valid;
      r_wr_en   <= id_wr_en & id_valid;
      r_opcode  <= id_opcode;
      r_rd      <= id_rd;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_use_rs  <= id_use_rs;
      r_use_rt  <= id_use_rt;
      r_use_imm <= id_use_imm;
      r_rs_data <= w_rs_cap;
      r_rt_data <= w_rt_cap;
      r_imm     <= id_imm;
    end
  end

  // Operand A: r0 or unused reads zero; EX/MEM beats MEM/WB beats captured.
  always_comb begin
    ex_op_a = '0;
    w_fwd_a = 1'b0;
    if (r_use_rs && r_rs != '0) begin
      if (exm_wr_en && exm_rd == r_rs) begin
        ex_op_a = exm_data;
        w_fwd_a = 1'b1;
      end else if (mwb_wr_en && mwb_rd == r_rs) begin
        ex_op_a = mwb_data;
        w_fwd_a = 1'b1;
      end else begin
        ex_op_a = r_rs_data;
      end
    end
  end

  // Operand B: immediate bypasses forwarding entirely; otherwise same as A on rt.
  always_comb begin
    ex_op_b = '0;
    w_fwd_b = 1'b0;
    if (r_use_imm) begin
      ex_op_b = r_imm;
    end else if (r_use_rt && r_rt != '0) begin
      if (exm_wr_en && exm_rd == r_rt) begin
        ex_op_b = exm_data;
        w_fwd_b = 1'b1;
      end else if (mwb_wr_en && mwb_rd == r_rt) begin
        ex_op_b = mwb_data;
        w_fwd_b = 1'b1;
      end else begin
        ex_op_b = r_rt_data;
      end
    end
  end

`ifdef OPSTAGE_PERF_CNT_EN
  logic [15:0] r_perf_bubbles, r_perf_fwds;
  assign perf_bubbles = r_perf_bubbles;
  assign perf_fwds    = r_perf_fwds;

  // Saturating counters: bubbles actually inserted, and cycles using a forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_bubbles <= '0;
      r_perf_fwds    <= '0;
    end else begin
      if (!flush && !stall_in && hazard_stall && r_perf_bubbles != 16'hFFFF)
        r_perf_bubbles <= r_perf_bubbles + 16'd1;
      if (r_valid && !stall_in && (w_fwd_a || w_fwd_b) && r_perf_fwds != 16'hFFFF)
        r_perf_fwds <= r_perf_fwds + 16'd1;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = w_fwd_a ^ w_fwd_b;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed table-driven bench for alu_operand_stage, plus hand sequences for
// reset behaviour (start-up and mid-stream asynchronous reset).
module tb_alu_operand_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs, id_use_rt, id_use_imm, id_wr_en;
  logic [3:0]    id_opcode;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          stall_in, flush;
  logic          exm_wr_en, mwb_wr_en;
  logic [RW-1:0] exm_rd, mwb_rd;
  logic [DW-1:0] exm_data, mwb_data;
  logic          hazard_stall, ex_valid, ex_wr_en;
  logic [3:0]    ex_opcode;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_op_a, ex_op_b;
`ifdef OPSTAGE_PERF_CNT_EN
  logic [15:0]   perf_bubbles, perf_fwds;
`endif

  alu_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_wr_en(id_wr_en),
    .stall_in(stall_in), .flush(flush),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b)
`ifdef OPSTAGE_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_fwds(perf_fwds)
`endif
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, then expected hazard (before the edge) and
  // expected ex_* after the edge. op/rd/a/b are only checked when x_ev=1.
  typedef struct {
    int vld, op, rs, rt, rd, urs, urt, uimm, wen, rsd, rtd, imm;
    int stall, flush, ew, erd, ed, mw, mrd, md;
    int x_hz, x_ev, x_wen, x_op, x_rd, x_a, x_b;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid   = 1'(v.vld);
    id_opcode  = 4'(v.op);
    id_rs      = 4'(v.rs);
    id_rt      = 4'(v.rt);
    id_rd      = 4'(v.rd);
    id_use_rs  = 1'(v.urs);
    id_use_rt  = 1'(v.urt);
    id_use_imm = 1'(v.uimm);
    id_wr_en   = 1'(v.wen);
    id_rs_data = 16'(v.rsd);
    id_rt_data = 16'(v.rtd);
    id_imm     = 16'(v.imm);
    stall_in   = 1'(v.stall);
    flush      = 1'(v.flush);
    exm_wr_en  = 1'(v.ew);
    exm_rd     = 4'(v.erd);
    exm_data   = 16'(v.ed);
    mwb_wr_en  = 1'(v.mw);
    mwb_rd     = 4'(v.mrd);
    mwb_data   = 16'(v.md);
  endtask

  initial begin
    //          vld op rs rt rd urs urt uim wen rsd      rtd      imm      stl fl ew erd ed       mw mrd md       hz ev wen op rd a        b
    vt[0]  = '{1, 0, 1, 2, 3, 1, 1, 0, 1, 'h0011, 'h0022, 0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 3, 'h0011, 'h0022};
    // RED r3,r3: EX/MEM 1234 beats MEM/WB 5555
    vt[1]  = '{1, 3, 3, 3, 4, 1, 1, 0, 1, 0,      0,      0,      0, 0, 1, 3, 'h1234, 1, 3, 'h5555, 0, 1, 1, 3, 4, 'h1234, 'h1234};
    // r0 source with exm_rd=0 reads zero
    vt[2]  = '{1, 0, 0, 1, 5, 1, 1, 0, 1, 'hFFFF, 'h0007, 0,      0, 0, 1, 0, 'hBEEF, 0, 0, 0,      0, 1, 1, 0, 5, 0,      'h0007};
    // LW r0, then use r0: no hazard
    vt[3]  = '{1, 8, 1, 0, 0, 1, 0, 0, 1, 'h0100, 0,      0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 8, 0, 'h0100, 0};
    vt[4]  = '{1, 0, 0, 0, 6, 1, 1, 0, 1, 'hFFFF, 'hFFFF, 0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 6, 0,      0};
    // LW r5, ADD rs=r5: one bubble, then MEM/WB forward
    vt[5]  = '{1, 8, 1, 0, 5, 1, 0, 0, 1, 'h0200, 0,      0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 8, 5, 'h0200, 0};
    vt[6]  = '{1, 0, 5, 2, 7, 1, 1, 0, 1, 0,      'h0009, 0,      0, 0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0, 0,      0};
    vt[7]  = '{1, 0, 5, 2, 7, 1, 1, 0, 1, 0,      'h0009, 0,      0, 0, 0, 0, 0,      1, 5, 'h4321, 0, 1, 1, 0, 7, 'h4321, 'h0009};
    // stall_in + flush on the same edge: flush wins
    vt[8]  = '{1, 0, 1, 2, 8, 1, 1, 0, 1, 'h00A0, 'h00B0, 0,      1, 1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,      0};
    vt[9]  = '{1, 0, 1, 2, 8, 1, 1, 0, 1, 'h00A0, 'h00B0, 0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 8, 'h00A0, 'h00B0};
    // stall_in for three cycles: everything holds
    vt[10] = '{1, 2, 3, 4, 9, 1, 1, 0, 0, 'h1111, 'h2222, 0,      1, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 8, 'h00A0, 'h00B0};
    vt[11] = '{1, 2, 3, 4, 9, 1, 1, 0, 0, 'h1111, 'h2222, 0,      1, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 8, 'h00A0, 'h00B0};
    vt[12] = '{1, 2, 3, 4, 9, 1, 1, 0, 0, 'h1111, 'h2222, 0,      1, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 8, 'h00A0, 'h00B0};
    // immediate B with exm_rd==rt: no forwarding on B
    vt[13] = '{1, 1, 1, 2, 10,1, 1, 1, 1, 'h0001, 'h0002, 'h00F0, 0, 0, 1, 2, 'hDEAD, 0, 0, 0,      0, 1, 1, 1, 10,'h0001, 'h00F0};
    // invalid ID: ex_wr_en gated by valid
    vt[14] = '{0, 0, 1, 2, 11,1, 1, 0, 1, 'h0001, 'h0002, 0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,      0};
    // LW r6, ADD rt=r6: second load-use bubble
    vt[15] = '{1, 8, 1, 0, 6, 1, 0, 0, 1, 'h0300, 0,      0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 8, 6, 'h0300, 0};
    vt[16] = '{1, 0, 2, 6, 9, 1, 1, 0, 1, 'h0002, 0,      0,      0, 0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0, 0,      0};
    vt[17] = '{1, 0, 2, 6, 9, 1, 1, 0, 1, 'h0002, 0,      0,      0, 0, 0, 0, 0,      1, 6, 'h0777, 0, 1, 1, 0, 9, 'h0002, 'h0777};
    // plain flush
    vt[18] = '{1, 0, 1, 2, 3, 1, 1, 0, 1, 'h0001, 'h0002, 0,      0, 1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,      0};
    // LW r5 then dependent ADD under flush: flush masks the hazard
    vt[19] = '{1, 8, 1, 0, 5, 1, 0, 0, 1, 'h0200, 0,      0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 8, 5, 'h0200, 0};
    vt[20] = '{1, 0, 5, 0, 7, 1, 0, 0, 1, 0,      0,      0,      0, 1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,      0};
    // ADD in EX before the mid-stream reset
    vt[21] = '{1, 0, 1, 0, 3, 1, 0, 0, 1, 'h0055, 0,      0,      0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 3, 'h0055, 0};

    rst_n = 1'b0;
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    chk("rst_ev",  0, int'(ex_valid),  0);
    chk("rst_wen", 0, int'(ex_wr_en),  0);
    chk("rst_op",  0, int'(ex_opcode), 0);
    chk("rst_rd",  0, int'(ex_rd),     0);
    chk("rst_a",   0, int'(ex_op_a),   0);
    chk("rst_b",   0, int'(ex_op_b),   0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk("hazard", i, int'(hazard_stall), vt[i].x_hz);
      @(posedge clk);
      #1;
      chk("ex_valid", i, int'(ex_valid), vt[i].x_ev);
      chk("ex_wr_en", i, int'(ex_wr_en), vt[i].x_wen);
      if (vt[i].x_ev != 0) begin
        chk("ex_opcode", i, int'(ex_opcode), vt[i].x_op);
        chk("ex_rd",     i, int'(ex_rd),     vt[i].x_rd);
        chk("ex_op_a",   i, int'(ex_op_a),   vt[i].x_a);
        chk("ex_op_b",   i, int'(ex_op_b),   vt[i].x_b);
      end
    end

`ifdef OPSTAGE_PERF_CNT_EN
    chk("perf_bubbles", NV, int'(perf_bubbles), 2);
`endif

    // Asynchronous reset between edges clears the stage immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ev",  NV, int'(ex_valid),  0);
    chk("mid_rst_wen", NV, int'(ex_wr_en),  0);
    chk("mid_rst_op",  NV, int'(ex_opcode), 0);
    chk("mid_rst_rd",  NV, int'(ex_rd),     0);
    chk("mid_rst_a",   NV, int'(ex_op_a),   0);
    chk("mid_rst_b",   NV, int'(ex_op_b),   0);
    @(negedge clk);
    rst_n = 1'b1;
    #10;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
